// File: rtl/ym_pkg.sv
// rtl/ym_pkg.sv - shared FSM states and phase counter types for the YM2151 write sequencer
package ym_pkg;

   localparam int PHASE_CNT_W = 16;

   typedef logic [PHASE_CNT_W-1:0] phase_cnt_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR_WR,
      ST_GAP,
      ST_DATA_WR,
      ST_BUSY_WAIT
   } ym_state_t;

   // Down-counting phases load "cycles - 1" so the phase ends when the counter reads zero.
   function automatic phase_cnt_t cnt_load(input int cycles);
      return phase_cnt_t'(cycles - 1);
   endfunction

endpackage

// File: rtl/ym_write_sequencer_if.sv
// rtl/ym_write_sequencer_if.sv - requester handshakes and YM2151 CPU-side write port
interface ym_write_sequencer_if;

   logic       r0_valid;
   logic       r0_ready;
   logic [7:0] r0_addr;
   logic [7:0] r0_data;

   logic       r1_valid;
   logic       r1_ready;
   logic [7:0] r1_addr;
   logic [7:0] r1_data;

   logic       ym_cs_n;
   logic       ym_wr_n;
   logic       ym_a0;
   logic [7:0] ym_dout;
   logic       ym_busy;

   // Requester / YM-core side
   modport master (
      output r0_valid, r0_addr, r0_data,
      output r1_valid, r1_addr, r1_data,
      input  r0_ready, r1_ready,
      input  ym_cs_n, ym_wr_n, ym_a0, ym_dout,
      output ym_busy
   );

   // Sequencer side
   modport slave (
      input  r0_valid, r0_addr, r0_data,
      input  r1_valid, r1_addr, r1_data,
      output r0_ready, r1_ready,
      output ym_cs_n, ym_wr_n, ym_a0, ym_dout,
      input  ym_busy
   );

endinterface

// File: rtl/ym_rr_arbiter.sv
// rtl/ym_rr_arbiter.sv - two-way round-robin arbiter with one-hot grant
module ym_rr_arbiter (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // A lone requester always wins; on a tie the one not served last wins.
   always_comb begin
      grant = valid;
      if (valid == 2'b11) begin
         grant = last_grant ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/ym_write_sequencer.sv
// rtl/ym_write_sequencer.sv - shares the YM2151 write port between CPU and music player
module ym_write_sequencer
   import ym_pkg::*;
#(
   parameter int WR_CYCLES   = 4,
   parameter int GAP_CYCLES  = 12,
   parameter int BUSY_SETTLE = 8,
   parameter int TIMEOUT     = 4095
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   ym_write_sequencer_if.slave  bus,
   output logic                 idle,
   output logic                 last_grant,
   output logic                 timeout_err,
   input  logic                 timeout_clr
);

   localparam phase_cnt_t WR_LOAD      = cnt_load(WR_CYCLES);
   localparam phase_cnt_t GAP_LOAD     = cnt_load(GAP_CYCLES);
   localparam phase_cnt_t SETTLE_LAST  = cnt_load(BUSY_SETTLE);
   localparam phase_cnt_t TIMEOUT_LAST = cnt_load(TIMEOUT);

   ym_state_t  state;
   phase_cnt_t phase_cnt;
   logic [7:0] data_q;
   logic [1:0] grant;
   logic       accept;

   ym_rr_arbiter u_arb (
      .valid      ({bus.r1_valid, bus.r0_valid}),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // Grants are only offered while idle, so a requester is never accepted mid-write.
   assign bus.r0_ready = (state == ST_IDLE) && grant[0];
   assign bus.r1_ready = (state == ST_IDLE) && grant[1];
   assign accept       = (state == ST_IDLE) && (grant != 2'b00);
   assign idle         = (state == ST_IDLE);

   // Write FSM: address strobe, gap, data strobe, then busy wait with settle window and timeout.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state       <= ST_IDLE;
         phase_cnt   <= '0;
         data_q      <= '0;
         last_grant  <= 1'b1;
         timeout_err <= 1'b0;
         bus.ym_cs_n <= 1'b1;
         bus.ym_wr_n <= 1'b1;
         bus.ym_a0   <= 1'b0;
         bus.ym_dout <= '0;
      end else begin
         // A timeout set further down overrides a clear in the same cycle.
         if (timeout_clr) begin
            timeout_err <= 1'b0;
         end
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  last_grant  <= grant[1];
                  bus.ym_dout <= grant[1] ? bus.r1_addr : bus.r0_addr;
                  data_q      <= grant[1] ? bus.r1_data : bus.r0_data;
                  bus.ym_a0   <= 1'b0;
                  bus.ym_cs_n <= 1'b0;
                  bus.ym_wr_n <= 1'b0;
                  phase_cnt   <= WR_LOAD;
                  state       <= ST_ADDR_WR;
               end
            end
            ST_ADDR_WR: begin
               if (phase_cnt == '0) begin
                  bus.ym_cs_n <= 1'b1;
                  bus.ym_wr_n <= 1'b1;
                  phase_cnt   <= GAP_LOAD;
                  state       <= ST_GAP;
               end else begin
                  phase_cnt <= phase_cnt - phase_cnt_t'(1);
               end
            end
            ST_GAP: begin
               if (phase_cnt == '0) begin
                  bus.ym_a0   <= 1'b1;
                  bus.ym_dout <= data_q;
                  bus.ym_cs_n <= 1'b0;
                  bus.ym_wr_n <= 1'b0;
                  phase_cnt   <= WR_LOAD;
                  state       <= ST_DATA_WR;
               end else begin
                  phase_cnt <= phase_cnt - phase_cnt_t'(1);
               end
            end
            ST_DATA_WR: begin
               if (phase_cnt == '0) begin
                  bus.ym_cs_n <= 1'b1;
                  bus.ym_wr_n <= 1'b1;
                  phase_cnt   <= '0;
                  state       <= ST_BUSY_WAIT;
               end else begin
                  phase_cnt <= phase_cnt - phase_cnt_t'(1);
               end
            end
            ST_BUSY_WAIT: begin
               // The counter now counts up from entry: busy is trusted only after the
               // settle window, and the wait is cut off on its TIMEOUT-th cycle.
               if ((phase_cnt >= SETTLE_LAST) && !bus.ym_busy) begin
                  state <= ST_IDLE;
               end else if (phase_cnt == TIMEOUT_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  phase_cnt <= phase_cnt + phase_cnt_t'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ym_write_sequencer.sv
// tb/tb_ym_write_sequencer.sv - self-checking bench for the YM2151 write sequencer
module tb_ym_write_sequencer;

   localparam int TMO_SHORT = 16;
   // Write timeline, in cycles after the accept cycle T.
   localparam int A_FIRST   = 1;
   localparam int A_LAST    = 4;
   localparam int D_FIRST   = 17;
   localparam int D_LAST    = 20;
   localparam int BW_FIRST  = 21;
   localparam int BW_SAMPLE = 28;

   logic sys_clk = 1'b0;
   logic sys_rst;
   logic idle, last_grant, timeout_err, timeout_clr;
   logic t_idle, t_last_grant, t_timeout_err, t_timeout_clr;

   ym_write_sequencer_if bus ();
   ym_write_sequencer_if tbus ();

   always #5 sys_clk = ~sys_clk;

   ym_write_sequencer dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .bus         (bus),
      .idle        (idle),
      .last_grant  (last_grant),
      .timeout_err (timeout_err),
      .timeout_clr (timeout_clr)
   );

   ym_write_sequencer #(.TIMEOUT(TMO_SHORT)) dut_to (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .bus         (tbus),
      .idle        (t_idle),
      .last_grant  (t_last_grant),
      .timeout_err (t_timeout_err),
      .timeout_clr (t_timeout_clr)
   );

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t  q0[$];
   wr_t  q1[$];
   int   h_plan[$];
   int   acc_cyc[$];
   int   acc_req[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   pulse_r1_at = -1;

   // Reference model of the write in flight, expressed as cycle offsets from the accept.
   bit         m_fl;
   int         m_t, m_d, m_h;
   logic [7:0] m_addr, m_data, m_dout;
   logic       m_a0, m_lastg;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_fl = 1'b0; m_a0 = 1'b0; m_dout = 8'h00; m_lastg = 1'b1;
   endtask

   task automatic push_wr(input int req, input logic [7:0] a, input logic [7:0] d);
      wr_t w;
      w.addr = a; w.data = d;
      if (req == 0) q0.push_back(w); else q1.push_back(w);
   endtask

   // Advance to just after the next rising edge and drive the main instance's inputs.
   task automatic tick();
      @(posedge sys_clk);
      cyc++;
      #1;
      bus.r0_valid = (q0.size() > 0);
      bus.r0_addr  = (q0.size() > 0) ? q0[0].addr : 8'($urandom);
      bus.r0_data  = (q0.size() > 0) ? q0[0].data : 8'($urandom);
      bus.r1_valid = (q1.size() > 0) || (cyc == pulse_r1_at);
      bus.r1_addr  = (q1.size() > 0) ? q1[0].addr : 8'($urandom);
      bus.r1_data  = (q1.size() > 0) ? q1[0].data : 8'($urandom);
      // Busy is random wherever the sequencer must ignore it.
      if (m_fl && cyc >= m_t + BW_SAMPLE) bus.ym_busy = (cyc < m_t + BW_FIRST + m_h);
      else                                 bus.ym_busy = 1'($urandom);
   endtask

   // Mid-cycle: compare the main instance against the model, then arbitrate in the model.
   task automatic sample();
      int o;
      bit strobe, g0, g1;
      #4;
      if (m_fl && cyc > m_d) m_fl = 1'b0;
      o = cyc - m_t;
      if (m_fl && o == A_FIRST) begin m_a0 = 1'b0; m_dout = m_addr; end
      if (m_fl && o == D_FIRST) begin m_a0 = 1'b1; m_dout = m_data; end
      strobe = m_fl && ((o >= A_FIRST && o <= A_LAST) || (o >= D_FIRST && o <= D_LAST));
      check("cs_n", bus.ym_cs_n, !strobe);
      check("wr_n", bus.ym_wr_n, !strobe);
      check("a0", bus.ym_a0, m_a0);
      check("dout", bus.ym_dout, m_dout);
      check("idle", idle, !m_fl);
      check("last_grant", last_grant, m_lastg);
      check("timeout_err", timeout_err, 0);
      g0 = 1'b0; g1 = 1'b0;
      if (!m_fl) begin
         if (bus.r0_valid && bus.r1_valid) begin g0 = m_lastg; g1 = !m_lastg; end
         else begin g0 = bus.r0_valid; g1 = bus.r1_valid; end
      end
      check("r0_ready", bus.r0_ready, g0);
      check("r1_ready", bus.r1_ready, g1);
      if (bus.r0_valid && bus.r0_ready) begin acc_cyc.push_back(cyc); acc_req.push_back(0); end
      if (bus.r1_valid && bus.r1_ready) begin acc_cyc.push_back(cyc); acc_req.push_back(1); end
      if (g0 || g1) begin
         m_fl    = 1'b1;
         m_t     = cyc;
         m_lastg = g1;
         m_addr  = g1 ? bus.r1_addr : bus.r0_addr;
         m_data  = g1 ? bus.r1_data : bus.r0_data;
         if (g0 && q0.size() > 0) void'(q0.pop_front());
         if (g1 && q1.size() > 0) void'(q1.pop_front());
         m_h = (h_plan.size() > 0) ? h_plan.pop_front() : 0;
         m_d = m_t + BW_FIRST + ((m_h > BW_SAMPLE - BW_FIRST) ? m_h : BW_SAMPLE - BW_FIRST);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin tick(); sample(); end
   endtask

   task automatic run_drain(input int max_cycles, input string tag);
      int n;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || m_fl) && n < max_cycles) begin
         tick(); sample(); n++;
      end
      check(tag, (n < max_cycles), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      int t0, n_acc;
      sys_rst = 1'b1;
      timeout_clr = 1'b0; t_timeout_clr = 1'b0;
      bus.r0_valid = 0; bus.r0_addr = 0; bus.r0_data = 0;
      bus.r1_valid = 0; bus.r1_addr = 0; bus.r1_data = 0; bus.ym_busy = 0;
      tbus.r0_valid = 0; tbus.r0_addr = 0; tbus.r0_data = 0;
      tbus.r1_valid = 0; tbus.r1_addr = 0; tbus.r1_data = 0; tbus.ym_busy = 0;
      model_reset();

      // Reset values on both instances.
      tick(); sample();
      tick(); sample();
      check("rst_t_idle", t_idle, 1);
      check("rst_t_last_grant", t_last_grant, 1);
      check("rst_t_err", t_timeout_err, 0);
      check("rst_t_cs_n", tbus.ym_cs_n, 1);
      check("rst_t_wr_n", tbus.ym_wr_n, 1);
      tick(); sys_rst = 1'b0; sample();
      run(3);

      // Both requesters valid continuously: r0, r1, r0, r1, 29 cycles apart.
      acc_cyc.delete(); acc_req.delete();
      for (int i = 0; i < 4; i++) begin
         push_wr(0, 8'($urandom), 8'($urandom));
         push_wr(1, 8'($urandom), 8'($urandom));
      end
      run_drain(400, "alt_drain");
      for (int i = 0; i < 4; i++)
         check("alt_grant", (acc_req.size() > i) ? acc_req[i] : -1, i % 2);
      for (int i = 1; i < 4; i++)
         check("alt_spacing", (acc_cyc.size() > i) ? acc_cyc[i] - acc_cyc[i-1] : -1, 29);

      // Single r0 write 0x08/0x78 with busy low from the first sample point.
      push_wr(0, 8'h08, 8'h78); h_plan.push_back(0);
      run_drain(60, "single_drain");
      run(2);

      // Busy held through the settle window and released at T+40.
      push_wr(0, 8'($urandom), 8'($urandom)); h_plan.push_back(19);
      run_drain(80, "busy40_drain");
      run(2);

      // One-cycle r1 pulse while the sequencer is busy must be ignored.
      n_acc = acc_req.size();
      push_wr(0, 8'h10, 8'h01); h_plan.push_back(0);
      for (int i = 0; i < 5 && !m_fl; i++) begin tick(); sample(); end
      pulse_r1_at = m_t + 10;
      run(45);
      pulse_r1_at = -1;
      check("pulse_accepts", acc_req.size() - n_acc, 1);

      // Randomized traffic from both requesters with random busy lengths.
      for (int i = 0; i < 8; i++) begin
         push_wr(int'($urandom_range(1, 0)), 8'($urandom), 8'($urandom));
         h_plan.push_back(int'($urandom_range(25, 0)));
      end
      run_drain(800, "rand_drain");
      run(3);

      // Reset during the data strobe drops the write and releases the strobes at once.
      push_wr(0, 8'hA5, 8'h3C); h_plan.push_back(0);
      for (int i = 0; i < 40 && !(m_fl && cyc == m_t + 18); i++) begin tick(); sample(); end
      check("rst_in_data_wr", bus.ym_wr_n, 0);
      sys_rst = 1'b1;
      #1;
      check("rst_async_cs_n", bus.ym_cs_n, 1);
      check("rst_async_wr_n", bus.ym_wr_n, 1);
      check("rst_async_idle", idle, 1);
      model_reset(); h_plan.delete();
      tick(); sample();
      tick(); sys_rst = 1'b0; sample();
      run(10);
      acc_cyc.delete(); acc_req.delete();
      push_wr(1, 8'($urandom), 8'($urandom));
      push_wr(0, 8'($urandom), 8'($urandom));
      run_drain(100, "post_rst_drain");
      check("post_rst_first", (acc_req.size() > 0) ? acc_req[0] : -1, 0);

      // Short-timeout instance: busy stuck high.
      tbus.ym_busy = 1'b1;
      tick(); tbus.r0_valid = 1'b1; tbus.r0_addr = 8'h20; tbus.r0_data = 8'h55; sample();
      check("to_ready", tbus.r0_ready, 1);
      t0 = cyc;
      tick(); tbus.r0_valid = 1'b0; sample();
      while (cyc < t0 + 36) begin
         tick(); sample();
         if (cyc == t0 + 20) check("to_data_wr", tbus.ym_wr_n, 0);
         if (cyc == t0 + 21) check("to_data_end", tbus.ym_wr_n, 1);
      end
      check("to_wait_idle", t_idle, 0);
      check("to_wait_err", t_timeout_err, 0);
      tick(); sample();
      check("to_done_idle", t_idle, 1);
      check("to_done_err", t_timeout_err, 1);
      tick(); t_timeout_clr = 1'b1; sample();
      check("to_err_hold", t_timeout_err, 1);
      tick(); t_timeout_clr = 1'b0; sample();
      check("to_err_clr", t_timeout_err, 0);

      // Clear on the same cycle as a new timeout: the set wins.
      tick(); tbus.r0_valid = 1'b1; tbus.r0_addr = 8'h21; tbus.r0_data = 8'h66; sample();
      check("to2_ready", tbus.r0_ready, 1);
      t0 = cyc;
      tick(); tbus.r0_valid = 1'b0; sample();
      while (cyc < t0 + 35) begin tick(); sample(); end
      tick(); t_timeout_clr = 1'b1; sample();
      check("to2_wait_err", t_timeout_err, 0);
      tick(); t_timeout_clr = 1'b0; sample();
      check("to2_done_idle", t_idle, 1);
      check("to2_set_wins", t_timeout_err, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
